mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between the instruction-fetch requester and the load/store requester.
- Sits between the fetch/memory-access units and the memory model.
- Runs one transaction at a time, with round-robin priority on conflict, a req/done handshake per requester and a req/ack handshake to memory.
- Captures read data in registers and returns it to the owning requester.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional bus-timeout abort is enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              arb_busy,
  output logic              arb_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Owner encoding: 0 = fetch port, 1 = data port.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant;
  logic                timeout_hit;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_BUSY) begin
      cnt_d = '0;
    end else if (!mem_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Abort on the BUSY cycle whose increment would reach the limit; an ack in that cycle wins.
  assign timeout_hit = (state_q == ST_BUSY) && !mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == ST_BUSY) begin
        timed_out_q <= timeout_hit;
      end
    end
  end

  assign arb_err = (state_q == ST_DONE) && timed_out_q;
`else
  logic unused_cfg;
  assign unused_cfg  = TIMEOUT_CYCLES[0];
  assign timeout_hit = 1'b0;
  assign arb_err     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant        = OWN_I;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          grant        = (if_req && d_req) ? ~last_owner_q : d_req;
          owner_d      = grant;
          last_owner_d = grant;
          mem_req_d    = 1'b1;
          mem_we_d     = (grant == OWN_D) && d_we;
          mem_addr_d   = (grant == OWN_D) ? d_addr : if_addr;
          mem_wdata_d  = (grant == OWN_D) ? d_wdata : '0;
          state_d      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = (state_q == ST_DONE) && (owner_q == OWN_I);
  assign d_done    = (state_q == ST_DONE) && (owner_q == OWN_D);
  assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expectations are queued when a request is
// issued and retired when the matching done pulse appears.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        arb_busy;
  logic        arb_err;

  logic        resp_ack;
  logic [31:0] resp_rdata;
  logic        spur_ack;
  logic        ack_en;
  int          ack_lat;
  int          busy_cnt;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    logic [31:0] exp_rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_if;
  logic [31:0] m_d;

  assign mem_ack   = resp_ack | spur_ack;
  assign mem_rdata = spur_ack ? 32'hBAD0BAD0 : resp_rdata;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_done(if_done),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_done(d_done),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .arb_busy(arb_busy),
    .arb_err(arb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected rdata follows the arbiter's hold-until-next-read rule.
  task automatic push_exp(input logic port, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [31:0] mem_data,
                          input logic err);
    exp_t e;
    e.port     = port;
    e.addr     = addr;
    e.we       = we;
    e.wdata    = wdata;
    e.mem_data = mem_data;
    e.err      = err;
    if (err) begin
      e.exp_rdata = 32'h0;
    end else if (we) begin
      e.exp_rdata = port ? m_d : m_if;
    end else begin
      e.exp_rdata = mem_data;
    end
    if (port) m_d = e.exp_rdata;
    else      m_if = e.exp_rdata;
    exp_q.push_back(e);
  endtask

  task automatic flush_model();
    exp_q.delete();
    m_if = 32'h0;
    m_d  = 32'h0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (if_done || d_done) seen = 1'b1;
    end
    if (!seen) check({tag, "_done_wait"}, 64'(0), 64'(1));
  endtask

  // Memory model: acks ack_lat BUSY cycles after the request, checks the request fields.
  initial begin
    resp_ack   = 1'b0;
    resp_rdata = 32'h0;
    busy_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (mem_req && reset) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          if (exp_q.size() == 0) begin
            check("req_without_exp", 64'(1), 64'(0));
          end else begin
            check("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            check("mem_we", 64'(mem_we), 64'(exp_q[0].we));
            if (exp_q[0].we) check("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
          end
        end
        if (ack_en && busy_cnt > ack_lat) begin
          resp_ack   = 1'b1;
          resp_rdata = (exp_q.size() == 0) ? 32'h0 :
                       (exp_q[0].we ? 32'h12345678 : exp_q[0].mem_data);
          busy_cnt   = 0;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && (if_done || d_done)) begin
      check("done_excl", 64'(if_done & d_done), 64'(0));
      check("mem_req_in_done", 64'(mem_req), 64'(0));
      check("busy_in_done", 64'(arb_busy), 64'(1));
      if (exp_q.size() == 0) begin
        check("unexp_done", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("done_port", 64'(d_done), 64'(e.port));
        check(e.port ? "d_rdata" : "if_rdata", 64'(e.port ? d_rdata : if_rdata),
              64'(e.exp_rdata));
        check("arb_err", 64'(arb_err), 64'(e.err));
        $display("txn port=%s addr=0x%08h we=%0d rdata=0x%08h err=%0d",
                 e.port ? "D" : "I", e.addr, e.we, e.port ? d_rdata : if_rdata, arb_err);
      end
    end
  end

  initial begin
    int hi;
    int errs;
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 32'h0;
    d_wdata  = 32'h0;
    spur_ack = 1'b0;
    ack_en   = 1'b1;
    ack_lat  = 0;
    flush_model();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    check("rst_done", 64'({if_done, d_done}), 64'(0));
    check("rst_busy_err", 64'({arb_busy, arb_err}), 64'(0));
    reset = 1'b1;
    tick();
    check("idle_busy", 64'(arb_busy), 64'(0));

    // Fetch with two wait cycles
    ack_lat = 2;
    push_exp(1'b0, 32'h100, 1'b0, 32'h0, 32'h00500093, 1'b0);
    if_req  = 1'b1;
    if_addr = 32'h100;
    tick();
    check("t1_mem_req", 64'(mem_req), 64'(1));
    check("t1_busy", 64'(arb_busy), 64'(1));
    wait_done("t1");
    if_req = 1'b0;
    tick();

    // Load then store: the store must leave d_rdata alone
    ack_lat = 1;
    push_exp(1'b1, 32'h300, 1'b0, 32'h0, 32'h11223344, 1'b0);
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    wait_done("t2_load");
    d_req = 1'b0;
    tick();
    ack_lat = 0;
    push_exp(1'b1, 32'h200, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h200;
    d_wdata = 32'hDEADBEEF;
    tick();
    check("t2_mem_we", 64'(mem_we), 64'(1));
    check("t2_mem_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    wait_done("t2_store");
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check("t2_if_rdata_kept", 64'(if_rdata), 64'(m_if));

    // Simultaneous requests from reset: I, D, I
    reset = 1'b0;
    flush_model();
    tick();
    reset = 1'b1;
    tick();
    ack_lat = 1;
    push_exp(1'b0, 32'h400, 1'b0, 32'h0, 32'hA0000001, 1'b0);
    push_exp(1'b1, 32'h500, 1'b0, 32'h0, 32'hB0000002, 1'b0);
    push_exp(1'b0, 32'h400, 1'b0, 32'h0, 32'hA0000003, 1'b0);
    if_req  = 1'b1;
    if_addr = 32'h400;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h500;
    wait_done("t3_a");
    wait_done("t3_b");
    wait_done("t3_c");
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    check("t3_d_rdata", 64'(d_rdata), 64'(32'hB0000002));

    // Reset in the middle of a data access
    ack_en = 1'b0;
    push_exp(1'b1, 32'h600, 1'b0, 32'h0, 32'hC0000004, 1'b0);
    d_req  = 1'b1;
    d_addr = 32'h600;
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("t4_mem_req", 64'(mem_req), 64'(0));
    check("t4_busy", 64'(arb_busy), 64'(0));
    check("t4_done", 64'({if_done, d_done}), 64'(0));
    check("t4_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    flush_model();
    push_exp(1'b1, 32'h600, 1'b0, 32'h0, 32'hC0000004, 1'b0);
    ack_en  = 1'b1;
    ack_lat = 1;
    reset   = 1'b1;
    check("t4_idle_after_rel", 64'(arb_busy), 64'(0));
    tick();
    check("t4_regrant", 64'(mem_req), 64'(1));
    check("t4_regrant_addr", 64'(mem_addr), 64'(32'h600));
    wait_done("t4");
    d_req = 1'b0;
    tick();

    // Spurious ack while idle
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    check("t5_busy", 64'(arb_busy), 64'(0));
    tick();
    check("t5_busy2", 64'(arb_busy), 64'(0));
    check("t5_if_rdata", 64'(if_rdata), 64'(m_if));
    check("t5_d_rdata", 64'(d_rdata), 64'(m_d));

    // Give if_rdata a nonzero value before the no-ack scenario
    ack_lat = 0;
    push_exp(1'b0, 32'h180, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);
    if_req  = 1'b1;
    if_addr = 32'h180;
    wait_done("t6_pre");
    if_req = 1'b0;
    tick();

    ack_en = 1'b0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    push_exp(1'b0, 32'h700, 1'b0, 32'h0, 32'h0, 1'b1);
    if_req  = 1'b1;
    if_addr = 32'h700;
    tick();
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      hi++;
    end
    if_req = 1'b0;
    check("t6_timeout_cycles", 64'(hi), 64'(15));
    check("t6_timeout_done", 64'(if_done), 64'(1));
    ack_en = 1'b1;
`else
    push_exp(1'b0, 32'h700, 1'b0, 32'h0, 32'h77770000, 1'b0);
    if_req  = 1'b1;
    if_addr = 32'h700;
    tick();
    hi   = 0;
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      hi   += int'(mem_req);
      errs += int'(arb_err);
    end
    check("t6_hold_req", 64'(hi), 64'(100));
    check("t6_no_err", 64'(errs), 64'(0));
    ack_en = 1'b1;
    wait_done("t6");
    if_req = 1'b0;
`endif
    tick();
    tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_idle", 64'(arb_busy), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
